seven_segment_mux: RTL and testbench

//  Time-multiplexed driver for a common-anode N-digit 7-segment display with per-digit

---
 rtl/seven_segment_mux.sv | 214 +++++++++++++++++++++
 tb/tb_seven_segment_mux.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_mux.sv
// Time-multiplexed driver for a common-anode N-digit 7-segment display.
// Per-digit decimal point, blanking and PWM brightness; display data is held in a
// shadow register that only updates on a frame boundary, so a frame never mixes
// old and new digits.
// Optional feature: define SEVSEG_BLINK_EN to enable per-digit blinking driven by
// blink_mask. Without it, blink_mask is accepted and ignored.
module seven_segment_mux #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BRIGHT_BITS  = 3,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4*DIGITS-1:0]    number,
  input  logic [DIGITS-1:0]      dp_in,
  input  logic [DIGITS-1:0]      blank,
  input  logic                   load,
  input  logic [BRIGHT_BITS-1:0] brightness,
  input  logic [DIGITS-1:0]      blink_mask,
  output logic [DIGITS-1:0]      anode,
  output logic [6:0]             segment,
  output logic                   dp,
  output logic                   frame_tick
);

  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  // The prescaler is kept as {subslot, count-within-subslot}; the subslot then falls
  // out directly instead of needing a divider on a flat counter.
  localparam int unsigned SUB = REFRESH_DIV >> BRIGHT_BITS;
  localparam int unsigned SW  = (SUB > 1) ? $clog2(SUB) : 1;

  localparam logic [IW-1:0] LastIdx = IW'(DIGITS - 1);
  localparam logic [SW-1:0] LastSub = SW'(SUB - 1);

  // Prescaler, digit index and load bookkeeping
  logic [SW-1:0]          sub_cnt_q, sub_cnt_d;
  logic [BRIGHT_BITS-1:0] subslot_q, subslot_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   load_pending_q, load_pending_d;

  // Shadow copy of the display data
  logic [4*DIGITS-1:0]    shadow_num_q, shadow_num_d;
  logic [DIGITS-1:0]      shadow_dp_q, shadow_dp_d;
  logic [DIGITS-1:0]      shadow_blank_q, shadow_blank_d;

  // Registered pin drivers
  logic [DIGITS-1:0]      anode_q, anode_d;
  logic [6:0]             segment_q, segment_d;
  logic                   dp_q, dp_d;
  logic                   frame_tick_q, frame_tick_d;

  logic                   sub_wrap;
  logic                   slot_end;
  logic                   frame_end;
  logic                   capture;
  logic [DIGITS-1:0]      blink_hide;

  logic [3:0]             sel_nib;
  logic                   sel_dp;
  logic                   sel_dark;
  logic                   lit;

  assign sub_wrap  = (sub_cnt_q == LastSub);
  assign slot_end  = sub_wrap && (subslot_q == '1);
  assign frame_end = slot_end && (idx_q == LastIdx);
  // A load arriving in the boundary cycle itself is taken in that boundary.
  assign capture   = frame_end && (load_pending_q || load);

  // Hex nibble to active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

`ifdef SEVSEG_BLINK_EN
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] LastFrame = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          blink_phase_q, blink_phase_d;

  // Frame counter advances with each frame boundary; phase flips on its wrap
  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_end) begin
      if (frame_cnt_q == LastFrame) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // Blink state registers; phase 0 (visible) out of reset
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  // blink_mask is used live, not through the shadow register
  assign blink_hide = blink_phase_q ? blink_mask : '0;
`else
  logic unused_blink;
  assign unused_blink = ^{blink_mask, BLINK_FRAMES[0]};
  assign blink_hide   = '0;
`endif

  // Prescaler, digit index, load_pending and shadow next-state
  always_comb begin
    sub_cnt_d      = sub_wrap ? '0 : sub_cnt_q + 1'b1;
    subslot_d      = sub_wrap ? subslot_q + 1'b1 : subslot_q;
    idx_d          = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
    end
    load_pending_d = capture ? 1'b0 : (load_pending_q || load);
    shadow_num_d   = shadow_num_q;
    shadow_dp_d    = shadow_dp_q;
    shadow_blank_d = shadow_blank_q;
    if (capture) begin
      shadow_num_d   = number;
      shadow_dp_d    = dp_in;
      shadow_blank_d = blank;
    end
  end

  // Pick the current digit's shadow data
  always_comb begin
    sel_nib  = '0;
    sel_dp   = 1'b0;
    sel_dark = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        sel_nib  = shadow_num_q[4*i +: 4];
        sel_dp   = shadow_dp_q[i];
        sel_dark = shadow_blank_q[i] || blink_hide[i];
      end
    end
  end

  assign lit = (subslot_q <= brightness) && !sel_dark;

  // Pin next-state; when dark everything is released to avoid ghosting
  always_comb begin
    for (int unsigned i = 0; i < DIGITS; i++) begin
      anode_d[i] = !(lit && (idx_q == IW'(i)));
    end
    segment_d    = lit ? decode(sel_nib) : 7'h7F;
    dp_d         = lit ? ~sel_dp : 1'b1;
    frame_tick_d = frame_end;
  end

  // All state, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      sub_cnt_q      <= '0;
      subslot_q      <= '0;
      idx_q          <= '0;
      load_pending_q <= 1'b0;
      shadow_num_q   <= '0;
      shadow_dp_q    <= '0;
      shadow_blank_q <= '0;
      anode_q        <= '1;
      segment_q      <= 7'h7F;
      dp_q           <= 1'b1;
      frame_tick_q   <= 1'b0;
    end else begin
      sub_cnt_q      <= sub_cnt_d;
      subslot_q      <= subslot_d;
      idx_q          <= idx_d;
      load_pending_q <= load_pending_d;
      shadow_num_q   <= shadow_num_d;
      shadow_dp_q    <= shadow_dp_d;
      shadow_blank_q <= shadow_blank_d;
      anode_q        <= anode_d;
      segment_q      <= segment_d;
      dp_q           <= dp_d;
      frame_tick_q   <= frame_tick_d;
    end
  end

  assign anode      = anode_q;
  assign segment    = segment_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_segment_mux.sv
// Bench for seven_segment_mux: DIGITS=4, REFRESH_DIV=8, BRIGHT_BITS=2, BLINK_FRAMES=2,
// plus a DIGITS=3 instance. A time-based model predicts every output cycle.
module tb_seven_segment_mux;

  localparam int DG = 4;
  localparam int RD = 8;
  localparam int BB = 2;
  localparam int BF = 2;
`ifdef SEVSEG_BLINK_EN
  localparam bit BlinkOn = 1'b1;
`else
  localparam bit BlinkOn = 1'b0;
`endif

  localparam logic [6:0] SegTab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02,
                                         7'h78, 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21,
                                         7'h06, 7'h0E};

  logic        clk = 1'b0;
  logic        reset, load;
  logic [15:0] number;
  logic [3:0]  dp_in, blank, blink_mask;
  logic [1:0]  brightness;
  logic [3:0]  anode;
  logic [6:0]  segment;
  logic        dp, frame_tick;
  logic [2:0]  anode3;
  logic [6:0]  segment3;
  logic        dp3, ft3;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int last3 = -1;

  always #5 clk = ~clk;

  seven_segment_mux #(.DIGITS(DG), .REFRESH_DIV(RD), .BRIGHT_BITS(BB), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .number(number), .dp_in(dp_in), .blank(blank), .load(load),
    .brightness(brightness), .blink_mask(blink_mask), .anode(anode), .segment(segment),
    .dp(dp), .frame_tick(frame_tick)
  );

  seven_segment_mux #(.DIGITS(3), .REFRESH_DIV(RD), .BRIGHT_BITS(BB), .BLINK_FRAMES(BF)) dut3 (
    .clk(clk), .reset(reset), .number(12'h321), .dp_in(3'b000), .blank(3'b000), .load(load),
    .brightness(brightness), .blink_mask(3'b000), .anode(anode3), .segment(segment3),
    .dp(dp3), .frame_tick(ft3)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, got, want);
    end
  endtask

  // ---------------- model: everything derived from time since reset ----------------
  int          m_t;
  logic [15:0] m_num;
  logic [3:0]  m_dp, m_blank;
  logic        m_pend;
  logic [3:0]  exp_anode;
  logic [6:0]  exp_seg;
  logic        exp_dp, exp_ft;
  logic        chk_on = 1'b0;
  logic        rst_at_edge;
  logic [1:0]  bright_at_edge;

  function automatic int digit_of(input int t);
    return (t / RD) % DG;
  endfunction

  function automatic logic boundary_at(input int t);
    return (t % (RD * DG)) == (RD * DG - 1);
  endfunction

  function automatic logic lit_at(input int t, input logic [1:0] br, input logic [3:0] sh_blank,
                                  input logic [3:0] bmask);
    int   sub   = (t % RD) / (RD >> BB);
    int   frame = t / (RD * DG);
    logic hide  = sh_blank[digit_of(t)];
    if (BlinkOn && bmask[digit_of(t)] && ((frame / BF) % 2 == 1)) hide = 1'b1;
    return (sub <= int'(br)) && !hide;
  endfunction

  always @(posedge clk) begin
    cyc            <= cyc + 1;
    chk_on         <= 1'b1;
    rst_at_edge    <= reset;
    bright_at_edge <= brightness;
    if (reset) begin
      exp_anode <= 4'hF;
      exp_seg   <= 7'h7F;
      exp_dp    <= 1'b1;
      exp_ft    <= 1'b0;
      m_t       <= 0;
      m_num     <= '0;
      m_dp      <= '0;
      m_blank   <= '0;
      m_pend    <= 1'b0;
    end else begin
      if (lit_at(m_t, brightness, m_blank, blink_mask)) begin
        exp_anode <= ~(4'b0001 << digit_of(m_t));
        exp_seg   <= SegTab[m_num[4*digit_of(m_t) +: 4]];
        exp_dp    <= ~m_dp[digit_of(m_t)];
      end else begin
        exp_anode <= 4'hF;
        exp_seg   <= 7'h7F;
        exp_dp    <= 1'b1;
      end
      exp_ft <= boundary_at(m_t);
      if (boundary_at(m_t) && (m_pend || load)) begin
        m_num   <= number;
        m_dp    <= dp_in;
        m_blank <= blank;
        m_pend  <= 1'b0;
      end else if (load) begin
        m_pend <= 1'b1;
      end
      m_t <= m_t + 1;
    end
  end

  // Per-cycle compare against the model, plus DIGITS=3 invariants
  always @(negedge clk) begin
    if (chk_on) begin
      check("anode", anode, exp_anode);
      check("segment", segment, exp_seg);
      check("dp", dp, exp_dp);
      check("frame_tick", frame_tick, exp_ft);
      if (rst_at_edge) begin
        last3 = -1;
      end else begin
        if (bright_at_edge == 2'd3) check("dut3_anode_dark", anode3 == 3'b111, 1'b0);
        if (ft3) begin
          if (last3 >= 0) check("dut3_frame_period", cyc - last3, 24);
          last3 = cyc;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick(input string name);
    tick(1);
    for (int k = 0; k < 200 && frame_tick !== 1'b1; k++) tick(1);
    check(name, frame_tick, 1'b1);
  endtask

  task automatic count_frame(output int lit, output int d2on, output int dplow);
    lit = 0; d2on = 0; dplow = 0;
    for (int k = 0; k < RD * DG; k++) begin
      tick(1);
      if (anode !== 4'hF) lit++;
      if (anode[2] === 1'b0) d2on++;
      if (dp === 1'b0) dplow++;
    end
  endtask

  initial begin
    int lit, d2on, dplow, d0, d1;
    logic [3:0] first_an;
    logic [6:0] first_seg;
    reset = 1'b1; load = 1'b0; number = '0; dp_in = '0; blank = '0;
    brightness = 2'd3; blink_mask = '0;
    tick(3);
    reset = 1'b0;
    tick(2);

    // 1234 appears after the first boundary, digit 0 rightmost
    number = 16'h1234; load = 1'b1; tick(1); load = 1'b0;
    wait_tick("tick_first_frame");
    tick(1); check("d0_anode", anode, 4'b1110); check("d0_seg_4", segment, 7'h19);
    tick(8); check("d1_anode", anode, 4'b1101); check("d1_seg_3", segment, 7'h30);
    tick(8); check("d2_anode", anode, 4'b1011); check("d2_seg_2", segment, 7'h24);
    tick(8); check("d3_anode", anode, 4'b0111); check("d3_seg_1", segment, 7'h79);

    // Mid-frame load: old digit 3 still shown until the boundary
    tick(2); number = 16'h00AF; load = 1'b1; tick(1); load = 1'b0;
    wait_tick("tick_after_midload");
    check("old_d3_seg", segment, 7'h79);
    tick(1); check("new_d0_seg_F", segment, 7'h0E);
    tick(8); check("new_d1_seg_A", segment, 7'h08);

    // Load raised exactly in the boundary cycle is captured there
    wait_tick("tick_align");
    tick(31); number = 16'h5678; load = 1'b1; tick(1); load = 1'b0;
    check("boundary_tick", frame_tick, 1'b1);
    check("boundary_old_d3", segment, 7'h40);
    tick(1); check("boundary_new_d0_8", segment, 7'h00);

    // Brightness duty: 2/8 and 4/8 of each slot
    brightness = 2'd0; wait_tick("tick_b0");
    count_frame(lit, d2on, dplow); check("bright0_lit_cycles", lit, 8);
    brightness = 2'd1; wait_tick("tick_b1");
    count_frame(lit, d2on, dplow); check("bright1_lit_cycles", lit, 16);

    // Blank digit 2, decimal point on digit 0
    brightness = 2'd3; blank = 4'b0100; dp_in = 4'b0001;
    load = 1'b1; tick(1); load = 1'b0;
    wait_tick("tick_blank");
    count_frame(lit, d2on, dplow);
    check("blank_lit_cycles", lit, 24);
    check("blank_d2_enabled", d2on, 0);
    check("dp_low_cycles", dplow, 8);

    // Reset in the middle of a slot
    tick(3); reset = 1'b1; tick(1);
    check("rst_anode", anode, 4'hF); check("rst_seg", segment, 7'h7F);
    check("rst_dp", dp, 1'b1); check("rst_ft", frame_tick, 1'b0);
    reset = 1'b0; blank = '0; blink_mask = 4'b0001;
    for (int f = 0; f < 4; f++) begin
      d0 = 0; d1 = 0;
      for (int k = 0; k < RD * DG; k++) begin
        tick(1);
        if (f == 0 && k == 0) begin first_an = anode; first_seg = segment; end
        if (anode === 4'b1110) d0++;
        if (anode === 4'b1101) d1++;
      end
      if (f == 0) begin
        check("post_rst_anode", first_an, 4'b1110);
        check("post_rst_seg_0", first_seg, 7'h40);
      end
      check("blink_d0_cycles", d0, (BlinkOn && f >= 2) ? 0 : 8);
      check("blink_d1_cycles", d1, 8);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
